vx_rop_blend_sched: RTL and testbench

Shares one pipelined per-channel min/max blend datapath among `NUM_REQS` ROP blend requesters. Each cycle it arbitrates the requesters, issues at most one src/dst RGBA pair into a `LATENCY`-deep pipeline, and tracks the requester tag and min/max mode alongside it. It returns the selected result on a single tagged response channel and stalls the whole pipeline on response back-pressure. It sits between the per-fragment blend request queues and the ROP output merge.

---
 rtl/vx_rop_blend_sched.sv | 130 +++++++++++++
 tb/tb_vx_rop_blend_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vx_rop_blend_sched.sv
// Shared per-channel min/max blend pipeline arbitrated among NUM_REQS requesters.
// Define VX_ROP_BLEND_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module vx_rop_blend_sched #(
  parameter int NUM_REQS = 4,
  parameter int LATENCY  = 1,
  parameter int TAGW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQS-1:0]      req_valid,
  input  logic [NUM_REQS*32-1:0]   req_src,
  input  logic [NUM_REQS*32-1:0]   req_dst,
  input  logic [NUM_REQS-1:0]      req_mode,
  output logic [NUM_REQS-1:0]      req_ready,
  output logic                     rsp_valid,
  output logic [TAGW-1:0]          rsp_tag,
  output logic                     rsp_mode,
  output logic [31:0]              rsp_color,
  input  logic                     rsp_ready
);

  logic                            en;
  logic                            gnt_any;
  logic [TAGW-1:0]                 gnt_idx;
  logic [31:0]                     src_d, dst_d;
  logic                            mode_d;

  logic [LATENCY-1:0]              vld_q;
  logic [LATENCY-1:0][TAGW-1:0]    tag_q;
  logic [LATENCY-1:0]              mode_q;
  logic [LATENCY-1:0][31:0]        src_q;
  logic [LATENCY-1:0][31:0]        dst_q;

  assign en = !(rsp_valid && !rsp_ready);

`ifdef VX_ROP_BLEND_RR_EN
  logic [TAGW-1:0] ptr_q, ptr_d;
  logic [TAGW-1:0] cand;
  int              idx;

  // Search starts at ptr and wraps; first valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    if (en && !reset) begin
      for (int k = 0; k < NUM_REQS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQS) idx = idx - NUM_REQS;
        cand = TAGW'(idx);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == TAGW'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)   ptr_q <= '0;
    else if (en) ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (en && !reset) begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        if (req_valid[k]) begin
          gnt_any = 1'b1;
          gnt_idx = TAGW'(k);
        end
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign src_d  = req_src[32*int'(gnt_idx) +: 32];
  assign dst_d  = req_dst[32*int'(gnt_idx) +: 32];
  assign mode_d = req_mode[gnt_idx];

  // Whole pipeline, bubbles included, advances only on en.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      tag_q  <= '0;
      mode_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
    end else if (en) begin
      vld_q[0]  <= gnt_any;
      tag_q[0]  <= gnt_idx;
      mode_q[0] <= mode_d;
      src_q[0]  <= src_d;
      dst_q[0]  <= dst_d;
      for (int s = 1; s < LATENCY; s++) begin
        vld_q[s]  <= vld_q[s-1];
        tag_q[s]  <= tag_q[s-1];
        mode_q[s] <= mode_q[s-1];
        src_q[s]  <= src_q[s-1];
        dst_q[s]  <= dst_q[s-1];
      end
    end
  end

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_tag   = tag_q[LATENCY-1];
  assign rsp_mode  = mode_q[LATENCY-1];

  always_comb begin
    rsp_color = '0;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] s, d;
      logic       gt;
      s  = src_q[LATENCY-1][8*c +: 8];
      d  = dst_q[LATENCY-1][8*c +: 8];
      gt = s > d;
      rsp_color[8*c +: 8] = rsp_mode ? (gt ? s : d) : (gt ? d : s);
    end
  end

endmodule

// File: tb/tb_vx_rop_blend_sched.sv
// Directed bench: instance A (LATENCY=1) for blend/arbitration, instance B (LATENCY=3) for stall and reset.
module tb_vx_rop_blend_sched;

`ifdef VX_ROP_BLEND_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_reset, a_rsp_valid, a_rsp_mode, a_rsp_ready;
  logic [3:0]   a_req_valid, a_req_mode, a_req_ready;
  logic [127:0] a_req_src, a_req_dst;
  logic [1:0]   a_rsp_tag;
  logic [31:0]  a_rsp_color;

  logic         b_reset, b_rsp_valid, b_rsp_mode, b_rsp_ready;
  logic [3:0]   b_req_valid, b_req_mode, b_req_ready;
  logic [127:0] b_req_src, b_req_dst;
  logic [1:0]   b_rsp_tag;
  logic [31:0]  b_rsp_color;

  vx_rop_blend_sched #(.NUM_REQS(4), .LATENCY(1)) u_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_src(a_req_src),
    .req_dst(a_req_dst), .req_mode(a_req_mode), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_tag(a_rsp_tag), .rsp_mode(a_rsp_mode),
    .rsp_color(a_rsp_color), .rsp_ready(a_rsp_ready));

  vx_rop_blend_sched #(.NUM_REQS(4), .LATENCY(3)) u_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_src(b_req_src),
    .req_dst(b_req_dst), .req_mode(b_req_mode), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_tag(b_rsp_tag), .rsp_mode(b_rsp_mode),
    .rsp_color(b_rsp_color), .rsp_ready(b_rsp_ready));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] expq[$];
  int          issued, rcvd, exp_tag;
  logic        rdy, popnow, pushnow;
  logic [31:0] pushval;

  initial begin
    a_reset = 1'b1; a_req_valid = 4'hF; a_req_mode = '0; a_req_src = '0; a_req_dst = '0; a_rsp_ready = 1'b1;
    b_reset = 1'b1; b_req_valid = 4'hF; b_req_mode = '0; b_req_src = '0; b_req_dst = '0; b_rsp_ready = 1'b1;
    tick(); tick();
    chk("A_rst_ready", 32'(a_req_ready), 32'h0);
    chk("A_rst_valid", 32'(a_rsp_valid), 32'h0);
    chk("A_rst_tag",   32'(a_rsp_tag),   32'h0);
    chk("A_rst_color", a_rsp_color,      32'h0);

    // single issue, max then min
    a_reset = 1'b0;
    a_req_valid = 4'b0001; a_req_mode = 4'b0001;
    a_req_src[31:0] = 32'h10F02080; a_req_dst[31:0] = 32'h2050A080;
    #1 chk("A_ready0", 32'(a_req_ready), 32'h1);
    tick();
    a_req_mode = 4'b0000;
    chk("A_max_valid", 32'(a_rsp_valid), 32'h1);
    chk("A_max_tag",   32'(a_rsp_tag),   32'h0);
    chk("A_max_mode",  32'(a_rsp_mode),  32'h1);
    chk("A_max_color", a_rsp_color,      32'h20F0A080);
    tick();
    a_req_valid = 4'b0010; a_req_mode = 4'b0010;
    a_req_src[63:32] = 32'h7F7F7F7F; a_req_dst[63:32] = 32'h7F7F7F7F;
    chk("A_min_mode",  32'(a_rsp_mode),  32'h0);
    chk("A_min_color", a_rsp_color,      32'h10502080);
    tick();
    a_req_mode = 4'b0000;
    chk("A_tie_max_tag",   32'(a_rsp_tag), 32'h1);
    chk("A_tie_max_color", a_rsp_color,    32'h7F7F7F7F);
    tick();
    a_req_valid = 4'b0000;
    chk("A_tie_min_color", a_rsp_color,    32'h7F7F7F7F);
    tick();
    chk("A_idle_valid", 32'(a_rsp_valid), 32'h0);

    // fairness from ptr = 0
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_req_src[32*i +: 32] = 32'h01010101 * 32'(i + 1);
      a_req_dst[32*i +: 32] = 32'h0;
    end
    a_req_mode = 4'hF; a_req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      exp_tag = RR ? (k % 4) : 0;
      #1 chk("A_fair_ready", 32'(a_req_ready), 32'(1) << exp_tag);
      tick();
      chk("A_fair_valid", 32'(a_rsp_valid), 32'h1);
      chk("A_fair_tag",   32'(a_rsp_tag),   32'(exp_tag));
      chk("A_fair_color", a_rsp_color,      32'h01010101 * 32'(exp_tag + 1));
    end

    // wrap: ptr -> 3, lone req 1, then reqs 3 and 0
    a_req_valid = 4'b0100;
    #1 chk("A_wrap_r2", 32'(a_req_ready), 32'h4);
    tick();
    a_req_valid = 4'b0010;
    #1 chk("A_wrap_r1", 32'(a_req_ready), 32'h2);
    tick();
    chk("A_wrap_t1", 32'(a_rsp_tag), 32'h1);
    a_req_valid = 4'b1001;
    #1 chk("A_wrap_r3", 32'(a_req_ready), RR ? 32'h8 : 32'h1);
    tick();
    chk("A_wrap_t3", 32'(a_rsp_tag), RR ? 32'h3 : 32'h0);
    #1 chk("A_wrap_r0", 32'(a_req_ready), 32'h1);
    tick();
    a_req_valid = 4'b0000;
    chk("A_wrap_t0", 32'(a_rsp_tag), 32'h0);

    // back-pressure on a LATENCY=3 stream from req 2
    b_reset = 1'b0; b_req_valid = 4'b0000; b_req_mode = 4'b0100;
    issued = 0; rcvd = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      rdy = !(cyc >= 6 && cyc < 10);
      b_rsp_ready = rdy;
      b_req_valid = (issued < 10) ? 4'b0100 : 4'b0000;
      b_req_src[95:64] = 32'hA0000000 + 32'(issued);
      #1;
      chk("B_ready", 32'(b_req_ready),
          (issued < 10 && !(b_rsp_valid && !rdy)) ? 32'h4 : 32'h0);
      if (cyc == 6) chk("B_stall_valid", 32'(b_rsp_valid), 32'h1);
      if (b_rsp_valid) begin
        if (expq.size() == 0) chk("B_extra_rsp", 32'h1, 32'h0);
        else begin
          chk("B_color", b_rsp_color, expq[0]);
          chk("B_tag", 32'(b_rsp_tag), 32'h2);
        end
      end
      popnow  = b_rsp_valid && rdy && (expq.size() > 0);
      pushnow = b_req_valid[2] && b_req_ready[2];
      pushval = b_req_src[95:64];
      tick();
      if (popnow)  begin void'(expq.pop_front()); rcvd++; end
      if (pushnow) begin expq.push_back(pushval); issued++; end
    end
    chk("B_rcvd", 32'(rcvd), 32'd10);
    chk("B_left", 32'(expq.size()), 32'd0);

    // reset with three in flight behind a stalled output
    b_rsp_ready = 1'b0; b_req_mode = 4'b0111;
    b_req_src[31:0] = 32'h11111111;
    b_req_valid = 4'b0001; tick();
    b_req_valid = 4'b0010; tick();
    b_req_valid = 4'b0100; tick();
    b_req_valid = 4'b1111;
    #1 chk("B_held_valid", 32'(b_rsp_valid), 32'h1);
    chk("B_held_ready", 32'(b_req_ready), 32'h0);
    b_reset = 1'b1;
    tick();
    b_reset = 1'b0; b_rsp_ready = 1'b1;
    b_req_src[31:0] = 32'h22222222; b_req_dst[31:0] = 32'h0; b_req_mode = 4'b0001;
    #1;
    chk("B_rst_valid", 32'(b_rsp_valid), 32'h0);
    chk("B_rst_tag",   32'(b_rsp_tag),   32'h0);
    chk("B_rst_mode",  32'(b_rsp_mode),  32'h0);
    chk("B_rst_color", b_rsp_color,      32'h0);
    chk("B_rst_grant", 32'(b_req_ready), 32'h1);
    tick();
    b_req_valid = 4'b0000;
    chk("B_post1", 32'(b_rsp_valid), 32'h0);
    tick();
    chk("B_post2", 32'(b_rsp_valid), 32'h0);
    tick();
    chk("B_post3_valid", 32'(b_rsp_valid), 32'h1);
    chk("B_post3_tag",   32'(b_rsp_tag),   32'h0);
    chk("B_post3_color", b_rsp_color,      32'h22222222);
    tick();
    chk("B_post4", 32'(b_rsp_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
